// File: rtl/push_pop_pkg.sv
// Shared types and constants for the multi-register PUSH/POP sequencer.
package push_pop_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        READ_WAIT,
        MEM,
        WRITEBACK,
        SP_UPDATE,
        DONE
    } state_t;

    localparam logic [3:0] REG_LR     = 4'hE;
    localparam logic [3:0] REG_SP     = 4'hD;
    localparam int         WORD_BYTES = 4;
    localparam int         LIST_W     = 9;
    localparam logic [3:0] LR_BIT     = 4'd8;

    // Bytes occupied on the stack by a register list: popcount * word size.
    function automatic logic [31:0] list_bytes(input logic [LIST_W-1:0] list);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < LIST_W; i++) begin
            n = n + 32'(list[i]);
        end
        return n * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/lsb_encoder9.sv
// Lowest-set-bit index of a 9-bit register list, with a valid flag.
module lsb_encoder9
    import push_pop_pkg::*;
(
    input  logic [LIST_W-1:0] list,
    output logic [3:0]        index,
    output logic              valid
);

    // Scan downwards so the lowest set bit is the last one to win.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (list[i]) begin
                index = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/push_pop_sequencer.sv
// Sequences a multi-register PUSH/POP as one memory beat per register,
// lowest register first, then writes back the updated SP.
module push_pop_sequencer
    import push_pop_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_pop,
    input  logic [8:0]  reg_list,
    input  logic [31:0] sp_value,
    output logic        busy,
    output logic        done,
    output logic [3:0]  rf_rd_select,
    input  logic [31:0] rf_rd_data,
    output logic        rf_write_en,
    output logic [3:0]  rf_wr_select,
    output logic [31:0] rf_wr_data,
    output logic        rf_sp_write_en,
    output logic [31:0] rf_sp_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        pc_load,
    output logic [31:0] pc_value
);

    state_t              state;
    logic                pop;
    logic [LIST_W-1:0]   list;
    logic [LIST_W-1:0]   list_rest;
    logic [31:0]         addr;
    logic [31:0]         new_sp;
    logic [31:0]         start_bytes;
    logic [3:0]          lsb_idx;
    logic                lsb_valid;

    lsb_encoder9 u_lsb (
        .list  (list),
        .index (lsb_idx),
        .valid (lsb_valid)
    );

    assign start_bytes = list_bytes(reg_list);
    assign list_rest   = list & ~(list & (~list + LIST_W'(1)));

    // Outputs are registered on entry to the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pop            <= 1'b0;
            list           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            rf_rd_select   <= '0;
            rf_write_en    <= 1'b0;
            rf_wr_select   <= '0;
            rf_wr_data     <= '0;
            rf_sp_write_en <= 1'b0;
            rf_sp_in       <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            pc_load        <= 1'b0;
            pc_value       <= '0;
        end else begin
            done           <= 1'b0;
            rf_write_en    <= 1'b0;
            rf_sp_write_en <= 1'b0;
            pc_load        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pop    <= is_pop;
                        list   <= reg_list;
                        addr   <= is_pop ? sp_value : sp_value - start_bytes;
                        new_sp <= is_pop ? sp_value + start_bytes : sp_value - start_bytes;
                        busy   <= 1'b1;
                        if (reg_list == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    if (!lsb_valid) begin
                        state          <= SP_UPDATE;
                        rf_sp_write_en <= 1'b1;
                        rf_sp_in       <= new_sp;
                    end else if (pop) begin
                        state    <= MEM;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= addr;
                    end else begin
                        state        <= READ_WAIT;
                        rf_rd_select <= (lsb_idx == LR_BIT) ? REG_LR : lsb_idx;
                    end
                end
                READ_WAIT: begin
                    state     <= MEM;
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= addr;
                    mem_wdata <= rf_rd_data;
                end
                MEM: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        list    <= list_rest;
                        addr    <= addr + 32'(WORD_BYTES);
                        if (pop) begin
                            state <= WRITEBACK;
                            if (lsb_idx == LR_BIT) begin
                                pc_load  <= 1'b1;
                                pc_value <= mem_rdata;
                            end else begin
                                rf_write_en  <= 1'b1;
                                rf_wr_select <= lsb_idx;
                                rf_wr_data   <= mem_rdata;
                            end
                        end else if (list_rest != '0) begin
                            state <= SELECT;
                        end else begin
                            state          <= SP_UPDATE;
                            rf_sp_write_en <= 1'b1;
                            rf_sp_in       <= new_sp;
                        end
                    end
                end
                WRITEBACK: begin
                    if (list != '0) begin
                        state <= SELECT;
                    end else begin
                        state          <= SP_UPDATE;
                        rf_sp_write_en <= 1'b1;
                        rf_sp_in       <= new_sp;
                    end
                end
                SP_UPDATE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_push_pop_sequencer.sv
// Randomized bench for push_pop_sequencer against a transaction-level stack model.
module tb_push_pop_sequencer;

    logic        clk, rst, start, is_pop;
    logic [8:0]  reg_list;
    logic [31:0] sp_value;
    logic        busy, done;
    logic [3:0]  rf_rd_select;
    logic [31:0] rf_rd_data;
    logic        rf_write_en;
    logic [3:0]  rf_wr_select;
    logic [31:0] rf_wr_data;
    logic        rf_sp_write_en;
    logic [31:0] rf_sp_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        pc_load;
    logic [31:0] pc_value;

    push_pop_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .is_pop(is_pop), .reg_list(reg_list),
        .sp_value(sp_value), .busy(busy), .done(done), .rf_rd_select(rf_rd_select),
        .rf_rd_data(rf_rd_data), .rf_write_en(rf_write_en), .rf_wr_select(rf_wr_select),
        .rf_wr_data(rf_wr_data), .rf_sp_write_en(rf_sp_write_en), .rf_sp_in(rf_sp_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc_load(pc_load), .pc_value(pc_value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic        is_pc;
        logic [3:0]  sel;
        logic [31:0] data;
    } wr_t;

    int tests = 0;
    int fails = 0;

    beat_t       exp_beats[$];
    wr_t         exp_wr[$];
    logic [31:0] exp_sp;
    logic        sp_expected = 1'b0;
    logic [31:0] rf_model [16];
    logic [31:0] mem_model [logic [31:0]];
    int          mem_delay = 0;
    int          done_cnt = 0;
    int          sp_wr_cnt = 0;
    int          beats_acc = 0;
    int          evt_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0], ~a[31:16]};
    endfunction

    // Memory/register-file responder and output monitor.
    initial begin : responder
        beat_t b;
        wr_t   w;
        logic  beat_active;
        int    cnt;
        beat_active = 1'b0;
        cnt         = 0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        rf_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                beat_active = 1'b0;
                mem_ready   = 1'b0;
            end else begin
                if (rf_write_en | rf_sp_write_en | mem_req | pc_load) begin
                    evt_cnt++;
                    chk("excl", 32'($countones({rf_write_en, rf_sp_write_en, mem_req, pc_load})), 32'd1);
                end
                if (mem_req) begin
                    if (exp_beats.size() == 0) begin
                        chk("mem_unexp", 32'd1, 32'd0);
                    end else begin
                        b = exp_beats[0];
                        chk("mem_addr", mem_addr, b.addr);
                        chk("mem_we", 32'(mem_we), 32'(b.we));
                        if (b.we) chk("mem_wdata", mem_wdata, b.wdata);
                    end
                    if (!beat_active) begin
                        beat_active = 1'b1;
                        cnt = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
                    end
                    if (cnt == 0) begin
                        mem_ready   = 1'b1;
                        beat_active = 1'b0;
                        beats_acc++;
                        if (exp_beats.size() != 0) b = exp_beats.pop_front();
                        if (mem_we) mem_model[mem_addr] = mem_wdata;
                        else mem_rdata = mem_rd(mem_addr);
                    end else begin
                        cnt--;
                        mem_ready = 1'b0;
                        mem_rdata = $urandom;
                    end
                end else begin
                    mem_ready   = 1'b0;
                    beat_active = 1'b0;
                    mem_rdata   = $urandom;
                end
                if (rf_write_en) begin
                    if (exp_wr.size() == 0) chk("rf_wr_unexp", 32'd1, 32'd0);
                    else begin
                        w = exp_wr.pop_front();
                        chk("rf_wr_kind", 32'd0, 32'(w.is_pc));
                        chk("rf_wr_sel", 32'(rf_wr_select), 32'(w.sel));
                        chk("rf_wr_data", rf_wr_data, w.data);
                    end
                end
                if (pc_load) begin
                    if (exp_wr.size() == 0) chk("pc_unexp", 32'd1, 32'd0);
                    else begin
                        w = exp_wr.pop_front();
                        chk("pc_kind", 32'd1, 32'(w.is_pc));
                        chk("pc_value", pc_value, w.data);
                    end
                end
                if (rf_sp_write_en) begin
                    sp_wr_cnt++;
                    if (!sp_expected) chk("sp_unexp", 32'd1, 32'd0);
                    else chk("sp_value", rf_sp_in, exp_sp);
                end
                if (done) begin
                    done_cnt++;
                    chk("done_busy", 32'(busy), 32'd1);
                end
            end
            rf_rd_data = rf_model[rf_rd_select];
        end
    end

    // Expected transactions from the stack rules: one beat per set bit, ascending.
    task automatic build_model(input logic op, input logic [8:0] list, input logic [31:0] sp);
        int          n, k;
        logic [31:0] base;
        beat_t       b;
        wr_t         w;
        n      = $countones(list);
        base   = op ? sp : sp - 32'(4 * n);
        exp_sp = op ? sp + 32'(4 * n) : sp - 32'(4 * n);
        sp_expected = (n != 0);
        exp_beats.delete();
        exp_wr.delete();
        k = 0;
        for (int i = 0; i < 9; i++) begin
            if (list[i]) begin
                b.addr = base + 32'(4 * k);
                k++;
                if (!op) begin
                    b.we    = 1'b1;
                    b.wdata = rf_model[(i == 8) ? 14 : i];
                end else begin
                    b.we    = 1'b0;
                    b.wdata = '0;
                    w.is_pc = (i == 8);
                    w.sel   = 4'(i);
                    w.data  = mem_rd(b.addr);
                    exp_wr.push_back(w);
                end
                exp_beats.push_back(b);
            end
        end
        done_cnt  = 0;
        sp_wr_cnt = 0;
        beats_acc = 0;
    endtask

    task automatic launch(input logic op, input logic [8:0] list, input logic [31:0] sp, input int dly);
        @(negedge clk);
        mem_delay = dly;
        start     = 1'b1;
        is_pop    = op;
        reg_list  = list;
        sp_value  = sp;
        @(negedge clk);
        start     = 1'b0;
        is_pop    = 1'($urandom);
        reg_list  = 9'($urandom);
        sp_value  = $urandom;
    endtask

    task automatic run_op(input logic op, input logic [8:0] list, input logic [31:0] sp,
                          input int dly, input int glitch);
        int lat;
        lat = 0;
        build_model(op, list, sp);
        launch(op, list, sp, dly);
        for (int k = 1; k <= 400; k++) begin
            #1;
            if (k == 1) chk("busy_run", 32'(busy), 32'd1);
            if (k == glitch) begin
                start    = 1'b1;
                is_pop   = ~op;
                reg_list = 9'h1FF;
                sp_value = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done_cnt != 0) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
        if (list == '0) chk("zero_done_lat", 32'(lat), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("sp_writes", 32'(sp_wr_cnt), sp_expected ? 32'd1 : 32'd0);
        chk("beats_left", 32'(exp_beats.size()), 32'd0);
        chk("wr_left", 32'(exp_wr.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin : stimulus
        int snap;
        rst = 1'b1; start = 1'b0; is_pop = 1'b0; reg_list = '0; sp_value = '0;
        for (int i = 0; i < 16; i++) rf_model[i] = $urandom;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rf_we", 32'(rf_write_en), 32'd0);
        chk("rst_sp_we", 32'(rf_sp_write_en), 32'd0);
        chk("rst_pc_load", 32'(pc_load), 32'd0);
        chk("rst_selects", {20'd0, rf_rd_select, rf_wr_select, 4'd0}, 32'd0);
        chk("rst_data", rf_wr_data | rf_sp_in | pc_value, 32'd0);
        rst = 1'b0;

        // Directed PUSH r0,r1,LR at 0x1FFE and POP r0,r2,PC back.
        rf_model[0] = 32'h1111_0000; rf_model[1] = 32'h2222_0001; rf_model[14] = 32'hEEEE_000E;
        run_op(1'b0, 9'h103, 32'h0000_1FFE, 0, 0);
        chk("push_mem_r0", mem_rd(32'h1FF2), 32'h1111_0000);
        chk("push_mem_lr", mem_rd(32'h1FFA), 32'hEEEE_000E);
        mem_model[32'h1FF2] = 32'hA; mem_model[32'h1FF6] = 32'hB; mem_model[32'h1FFA] = 32'hC;
        run_op(1'b1, 9'h105, 32'h0000_1FF2, 0, 0);

        // Empty list, slow memory, wrap-around with an ignored start.
        run_op(1'b0, 9'h000, 32'h0000_1000, 0, 0);
        run_op(1'b1, 9'h000, 32'h0000_1000, 0, 0);
        run_op(1'b0, 9'h1F3, 32'h0000_8000, 3, 0);
        run_op(1'b0, 9'h003, 32'h0000_0004, 0, 3);
        chk("wrap_lo", mem_rd(32'hFFFF_FFFC), rf_model[0]);
        chk("wrap_hi", mem_rd(32'h0000_0000), rf_model[1]);

        // Reset in the MEM state of the second POP beat.
        build_model(1'b1, 9'h007, 32'h0000_4000);
        launch(1'b1, 9'h007, 32'h0000_4000, 3);
        for (int k = 0; k < 100; k++) begin
            #1;
            if (beats_acc == 1 && mem_req) break;
            @(negedge clk);
        end
        chk("rst_mid_reached", 32'(beats_acc == 1 && mem_req), 32'd1);
        rst = 1'b1;
        exp_beats.delete();
        exp_wr.delete();
        sp_expected = 1'b0;
        snap = evt_cnt;
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        repeat (10) @(negedge clk);
        #1;
        chk("rst_mid_no_writes", 32'(evt_cnt - snap), 32'd0);

        // Random operations with random memory latency.
        for (int t = 0; t < 25; t++) begin
            run_op(1'($urandom), 9'($urandom), $urandom, -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
